// File: rtl/xo_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xo_decode_pkg
//  Brief    : Shared constants, unit encoding and helpers for the XO-format
//             decode queue (POWER ISA 3.0B, primary opcode 31).
//  Revision : 1.0  initial release
// ============================================================================
package xo_decode_pkg;

    localparam logic [5:0] c_opc_xo = 6'd31;

    // Functional-unit class of a decoded op
    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_MUL = 2'd1,
        UNIT_DIV = 2'd2
    } unit_e;

    // XO extended opcodes (bits 22..30)
    localparam logic [8:0] c_xop_add     = 9'd266;
    localparam logic [8:0] c_xop_subf    = 9'd40;
    localparam logic [8:0] c_xop_addc    = 9'd10;
    localparam logic [8:0] c_xop_subfc   = 9'd8;
    localparam logic [8:0] c_xop_adde    = 9'd138;
    localparam logic [8:0] c_xop_subfe   = 9'd136;
    localparam logic [8:0] c_xop_addme   = 9'd234;
    localparam logic [8:0] c_xop_subfme  = 9'd232;
    localparam logic [8:0] c_xop_subfze  = 9'd200;
    localparam logic [8:0] c_xop_addze   = 9'd202;
    localparam logic [8:0] c_xop_neg     = 9'd104;
    localparam logic [8:0] c_xop_mullw   = 9'd235;
    localparam logic [8:0] c_xop_mulhwu  = 9'd11;
    localparam logic [8:0] c_xop_divw    = 9'd491;
    localparam logic [8:0] c_xop_divwu   = 9'd459;
    localparam logic [8:0] c_xop_divwe   = 9'd427;
    localparam logic [8:0] c_xop_divweu  = 9'd395;
    localparam logic [8:0] c_xop_mulld   = 9'd233;
    localparam logic [8:0] c_xop_mulhd   = 9'd73;
    localparam logic [8:0] c_xop_mulhdu  = 9'd9;
    localparam logic [8:0] c_xop_divd    = 9'd489;
    localparam logic [8:0] c_xop_divdu   = 9'd457;
    localparam logic [8:0] c_xop_divde   = 9'd425;
    localparam logic [8:0] c_xop_divdeu  = 9'd393;
    localparam logic [8:0] c_xop_addg6s  = 9'd74;

    // Op-table indices
    localparam logic [4:0] c_idx_add    = 5'd0;
    localparam logic [4:0] c_idx_subf   = 5'd1;
    localparam logic [4:0] c_idx_addc   = 5'd2;
    localparam logic [4:0] c_idx_subfc  = 5'd3;
    localparam logic [4:0] c_idx_adde   = 5'd4;
    localparam logic [4:0] c_idx_subfe  = 5'd5;
    localparam logic [4:0] c_idx_addme  = 5'd6;
    localparam logic [4:0] c_idx_subfme = 5'd7;
    localparam logic [4:0] c_idx_subfze = 5'd8;
    localparam logic [4:0] c_idx_addze  = 5'd9;
    localparam logic [4:0] c_idx_neg    = 5'd10;
    localparam logic [4:0] c_idx_mullw  = 5'd11;
    localparam logic [4:0] c_idx_mulhwu = 5'd12;
    localparam logic [4:0] c_idx_divw   = 5'd13;
    localparam logic [4:0] c_idx_divwu  = 5'd14;
    localparam logic [4:0] c_idx_divwe  = 5'd15;
    localparam logic [4:0] c_idx_divweu = 5'd16;
    localparam logic [4:0] c_idx_mulld  = 5'd17;
    localparam logic [4:0] c_idx_mulhd  = 5'd18;
    localparam logic [4:0] c_idx_mulhdu = 5'd19;
    localparam logic [4:0] c_idx_divd   = 5'd20;
    localparam logic [4:0] c_idx_divdu  = 5'd21;
    localparam logic [4:0] c_idx_divde  = 5'd22;
    localparam logic [4:0] c_idx_divdeu = 5'd23;
    localparam logic [4:0] c_idx_addg6s = 5'd24;

    // One decoded lane as stored in the FIFO
    typedef struct packed {
        logic       lv;
        logic       ill;
        logic [4:0] rt;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [8:0] xop;
        logic       oe;
        logic       rc;
        logic [1:0] unit;
        logic [4:0] idx;
    } lane_rec_t;

    localparam int c_lane_rec_w = $bits(lane_rec_t);

    // Width of a full bundle record in the FIFO
    function automatic int bundle_width(input int lanes);
        return lanes * c_lane_rec_w;
    endfunction

    // Op-table lookup: {hit, unit, idx}
    function automatic logic [7:0] xop_lookup(input logic [8:0] xop);
        logic [7:0] r;
        r = 8'd0;
        case (xop)
            c_xop_add:    r = {1'b1, UNIT_ALU, c_idx_add};
            c_xop_subf:   r = {1'b1, UNIT_ALU, c_idx_subf};
            c_xop_addc:   r = {1'b1, UNIT_ALU, c_idx_addc};
            c_xop_subfc:  r = {1'b1, UNIT_ALU, c_idx_subfc};
            c_xop_adde:   r = {1'b1, UNIT_ALU, c_idx_adde};
            c_xop_subfe:  r = {1'b1, UNIT_ALU, c_idx_subfe};
            c_xop_addme:  r = {1'b1, UNIT_ALU, c_idx_addme};
            c_xop_subfme: r = {1'b1, UNIT_ALU, c_idx_subfme};
            c_xop_subfze: r = {1'b1, UNIT_ALU, c_idx_subfze};
            c_xop_addze:  r = {1'b1, UNIT_ALU, c_idx_addze};
            c_xop_neg:    r = {1'b1, UNIT_ALU, c_idx_neg};
            c_xop_mullw:  r = {1'b1, UNIT_MUL, c_idx_mullw};
            c_xop_mulhwu: r = {1'b1, UNIT_MUL, c_idx_mulhwu};
            c_xop_divw:   r = {1'b1, UNIT_DIV, c_idx_divw};
            c_xop_divwu:  r = {1'b1, UNIT_DIV, c_idx_divwu};
            c_xop_divwe:  r = {1'b1, UNIT_DIV, c_idx_divwe};
            c_xop_divweu: r = {1'b1, UNIT_DIV, c_idx_divweu};
            c_xop_mulld:  r = {1'b1, UNIT_MUL, c_idx_mulld};
            c_xop_mulhd:  r = {1'b1, UNIT_MUL, c_idx_mulhd};
            c_xop_mulhdu: r = {1'b1, UNIT_MUL, c_idx_mulhdu};
            c_xop_divd:   r = {1'b1, UNIT_DIV, c_idx_divd};
            c_xop_divdu:  r = {1'b1, UNIT_DIV, c_idx_divdu};
            c_xop_divde:  r = {1'b1, UNIT_DIV, c_idx_divde};
            c_xop_divdeu: r = {1'b1, UNIT_DIV, c_idx_divdeu};
            c_xop_addg6s: r = {1'b1, UNIT_ALU, c_idx_addg6s};
            default:      r = 8'd0;
        endcase
        return r;
    endfunction

    // Ops that have no OE (overflow-enable) form
    function automatic logic xop_no_oe(input logic [8:0] xop);
        return (xop == c_xop_mulhwu) || (xop == c_xop_mulhdu) ||
               (xop == c_xop_mulhd)  || (xop == c_xop_addg6s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/xo_lane_decode.sv
`default_nettype none
// ============================================================================
//  Module   : xo_lane_decode
//  Brief    : Combinational XO-format decode of a single instruction lane.
//             Bit numbering follows the ISA: bit 0 is the word MSB.
//  Revision : 1.0  initial release
// ============================================================================
module xo_lane_decode
    import xo_decode_pkg::*;
#(
    parameter int OPC_W  = 6,
    parameter int WORD_W = 32
) (
    input  logic                    i_valid,
    input  logic [WORD_W-1:0]       i_insn,
    output logic [c_lane_rec_w-1:0] o_rec,
    output logic                    o_illegal
);

    logic [OPC_W-1:0] w_opc;
    logic [8:0]       w_xop;
    logic             w_oe;
    logic [7:0]       w_lookup;
    logic             w_is_xo;
    logic             w_oe_bad;
    logic             w_legal;
    lane_rec_t        w_rec;

    assign w_opc    = i_insn[WORD_W-1 -: OPC_W];
    assign w_xop    = i_insn[WORD_W-23 -: 9];
    assign w_oe     = i_insn[WORD_W-22];
    assign w_lookup = xop_lookup(w_xop);
    assign w_is_xo  = i_valid && (w_opc == OPC_W'(c_opc_xo));
    assign w_oe_bad = xop_no_oe(w_xop) && w_oe;
    assign w_legal  = w_is_xo && w_lookup[7] && !w_oe_bad;

    // Assemble the lane record; fields only for opcode-31 lanes, class only for legal ones
    always_comb begin
        w_rec     = '0;
        w_rec.lv  = w_legal;
        w_rec.ill = w_is_xo && !w_legal;
        if (w_is_xo) begin
            w_rec.rt  = i_insn[WORD_W-7  -: 5];
            w_rec.ra  = i_insn[WORD_W-12 -: 5];
            w_rec.rb  = i_insn[WORD_W-17 -: 5];
            w_rec.xop = w_xop;
            w_rec.oe  = w_oe;
            w_rec.rc  = i_insn[WORD_W-32];
        end
        if (w_legal) begin
            w_rec.unit = w_lookup[6:5];
            w_rec.idx  = w_lookup[4:0];
        end
    end

    assign o_rec     = w_rec;
    assign o_illegal = w_rec.ill;

endmodule
`default_nettype wire

// File: rtl/xo_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : xo_decode_queue
//  Brief    : Multi-lane XO decoder feeding a DEPTH-entry bundle FIFO with
//             valid/ready handshake, flush and saturating illegal-lane count.
//  Revision : 1.0  initial release
// ============================================================================
module xo_decode_queue
    import xo_decode_pkg::*;
#(
    parameter int opcodeWidth      = 6,
    parameter int xOpCodeWidth     = 9,
    parameter int regWidth         = 5,
    parameter int instructionWidth = 32,
    parameter int LANES            = 2,
    parameter int DEPTH            = 4
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           flush_i,
    input  logic                           valid_i,
    input  logic [LANES-1:0]               laneValid_i,
    input  logic [LANES*instructionWidth-1:0] instruction_i,
    output logic                           ready_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [LANES-1:0]               laneValid_o,
    output logic [LANES-1:0]               illegal_o,
    output logic [LANES*regWidth-1:0]      reg1_o,
    output logic [LANES*regWidth-1:0]      reg2_o,
    output logic [LANES*regWidth-1:0]      reg3_o,
    output logic [LANES*xOpCodeWidth-1:0]  xOpCode_o,
    output logic [LANES-1:0]               oe_o,
    output logic [LANES-1:0]               rc_o,
    output logic [LANES*2-1:0]             unit_o,
    output logic [LANES*5-1:0]             opIdx_o,
    output logic [15:0]                    illegalCount_o
);

    localparam int             REC_W   = bundle_width(LANES);
    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(DEPTH);

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [15:0]      r_ill_cnt;

    logic [REC_W-1:0] w_bundle;
    logic [REC_W-1:0] w_head;
    logic [LANES-1:0] w_in_ill;
    logic             w_push;
    logic             w_pop;
    logic [16:0]      w_ill_sum;

    assign ready_o        = (r_count != c_depth);
    assign valid_o        = (r_count != '0);
    assign w_push         = valid_i && ready_o && !flush_i;
    assign w_pop          = valid_o && ready_i && !flush_i;
    assign w_head         = r_mem[r_rd_ptr];
    assign illegalCount_o = r_ill_cnt;

    // Per-lane decode at the input and unpacking of the head entry
    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            lane_rec_t w_out_rec;

            xo_lane_decode #(
                .OPC_W  (opcodeWidth),
                .WORD_W (instructionWidth)
            ) u_dec (
                .i_valid   (laneValid_i[k]),
                .i_insn    (instruction_i[k*instructionWidth +: instructionWidth]),
                .o_rec     (w_bundle[k*c_lane_rec_w +: c_lane_rec_w]),
                .o_illegal (w_in_ill[k])
            );

            // Payload is forced to zero while the FIFO is empty
            assign w_out_rec = valid_o ? lane_rec_t'(w_head[k*c_lane_rec_w +: c_lane_rec_w])
                                       : lane_rec_t'('0);

            assign laneValid_o[k]                          = w_out_rec.lv;
            assign illegal_o[k]                            = w_out_rec.ill;
            assign reg1_o[k*regWidth +: regWidth]          = regWidth'(w_out_rec.rt);
            assign reg2_o[k*regWidth +: regWidth]          = regWidth'(w_out_rec.ra);
            assign reg3_o[k*regWidth +: regWidth]          = regWidth'(w_out_rec.rb);
            assign xOpCode_o[k*xOpCodeWidth +: xOpCodeWidth] = xOpCodeWidth'(w_out_rec.xop);
            assign oe_o[k]                                 = w_out_rec.oe;
            assign rc_o[k]                                 = w_out_rec.rc;
            assign unit_o[k*2 +: 2]                        = w_out_rec.unit;
            assign opIdx_o[k*5 +: 5]                       = w_out_rec.idx;
        end
    endgenerate

    // Running illegal count plus the illegal lanes of the incoming bundle
    always_comb begin
        w_ill_sum = {1'b0, r_ill_cnt};
        for (int i = 0; i < LANES; i++) begin
            w_ill_sum = w_ill_sum + 17'(w_in_ill[i]);
        end
    end

    // Bundle storage; contents are don't-care until written, outputs are gated by valid_o
    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_bundle;
        end
    end

    // Pointers, occupancy and saturating illegal counter
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ill_cnt <= '0;
        end else begin
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
            if (w_push) begin
                r_ill_cnt <= w_ill_sum[16] ? 16'hFFFF : w_ill_sum[15:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xo_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xo_decode_queue
//  Brief    : Self-checking bench for xo_decode_queue with a reference model
//             and a scoreboard of expected head bundles.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xo_decode_queue;

    localparam int LANES = 2;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              vin;
    logic [LANES-1:0]  lv_in;
    logic [LANES*32-1:0] insn;
    logic              rdy_in;
    logic              ready_o, valid_o;
    logic [LANES-1:0]  laneValid_o, illegal_o, oe_o, rc_o;
    logic [LANES*5-1:0] reg1_o, reg2_o, reg3_o, opIdx_o;
    logic [LANES*9-1:0] xop_o;
    logic [LANES*2-1:0] unit_o;
    logic [15:0]       illcnt_o;

    always #5 clk = ~clk;

    xo_decode_queue #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .flush_i        (flush),
        .valid_i        (vin),
        .laneValid_i    (lv_in),
        .instruction_i  (insn),
        .ready_o        (ready_o),
        .valid_o        (valid_o),
        .ready_i        (rdy_in),
        .laneValid_o    (laneValid_o),
        .illegal_o      (illegal_o),
        .reg1_o         (reg1_o),
        .reg2_o         (reg2_o),
        .reg3_o         (reg3_o),
        .xOpCode_o      (xop_o),
        .oe_o           (oe_o),
        .rc_o           (rc_o),
        .unit_o         (unit_o),
        .opIdx_o        (opIdx_o),
        .illegalCount_o (illcnt_o)
    );

    typedef struct packed {
        logic       lv;
        logic       ill;
        logic [4:0] rt;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [8:0] xop;
        logic       oe;
        logic       rc;
        logic [1:0] unit;
        logic [4:0] idx;
    } exp_t;
    typedef exp_t [LANES-1:0] bund_t;

    bund_t       sb[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned m_ill = 0;

    // Op table straight from the ISA listing: position = op index
    int tbl_xop [25] = '{266, 40, 10, 8, 138, 136, 234, 232, 200, 202, 104,
                         235, 11, 491, 459, 427, 395, 233, 73, 9,
                         489, 457, 425, 393, 74};
    int tbl_unit[25] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         1, 1, 2, 2, 2, 2, 1, 1, 1,
                         2, 2, 2, 2, 0};

    function automatic exp_t model(input logic v, input logic [31:0] w);
        exp_t e;
        int   pos;
        bit   no_oe;
        e   = '0;
        pos = -1;
        if (!v || (w >> 26) != 32'd31) return e;
        e.rt  = 5'((w >> 21) & 32'h1F);
        e.ra  = 5'((w >> 16) & 32'h1F);
        e.rb  = 5'((w >> 11) & 32'h1F);
        e.oe  = w[10];
        e.xop = 9'((w >> 1) & 32'h1FF);
        e.rc  = w[0];
        for (int i = 0; i < 25; i++) if (tbl_xop[i] == int'(e.xop)) pos = i;
        no_oe = (e.xop == 9'd11) || (e.xop == 9'd9) || (e.xop == 9'd73) || (e.xop == 9'd74);
        if (pos < 0 || (no_oe && e.oe)) begin
            e.ill = 1'b1;
        end else begin
            e.lv   = 1'b1;
            e.unit = 2'(tbl_unit[pos]);
            e.idx  = 5'(pos);
        end
        return e;
    endfunction

    function automatic bund_t actual();
        bund_t b;
        for (int k = 0; k < LANES; k++) begin
            b[k].lv   = laneValid_o[k];
            b[k].ill  = illegal_o[k];
            b[k].rt   = reg1_o[k*5 +: 5];
            b[k].ra   = reg2_o[k*5 +: 5];
            b[k].rb   = reg3_o[k*5 +: 5];
            b[k].xop  = xop_o[k*9 +: 9];
            b[k].oe   = oe_o[k];
            b[k].rc   = rc_o[k];
            b[k].unit = unit_o[k*2 +: 2];
            b[k].idx  = opIdx_o[k*5 +: 5];
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: compare head against model, then advance the model
    always @(negedge clk) begin
        bit    e_valid, e_ready, push, pop;
        bund_t act, exp, nb;
        if (rst) begin
            sb.delete();
            m_ill = 0;
        end else begin
            e_valid = (sb.size() != 0);
            e_ready = (sb.size() != DEPTH);
            chk("valid_o", 64'(valid_o), 64'(e_valid));
            chk("ready_o", 64'(ready_o), 64'(e_ready));
            chk("illegalCount_o", 64'(illcnt_o), 64'(m_ill));
            act = actual();
            exp = e_valid ? sb[0] : '0;
            for (int k = 0; k < LANES; k++) chk($sformatf("head_lane%0d", k), 64'(act[k]), 64'(exp[k]));
            push = vin && e_ready && !flush;
            pop  = e_valid && rdy_in && !flush;
            if (flush) begin
                sb.delete();
            end else begin
                if (pop) void'(sb.pop_front());
                if (push) begin
                    for (int k = 0; k < LANES; k++) begin
                        nb[k] = model(lv_in[k], insn[k*32 +: 32]);
                        if (nb[k].ill) m_ill = (m_ill == 32'hFFFF) ? m_ill : m_ill + 1;
                    end
                    sb.push_back(nb);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] lv, input logic [31:0] w0, input logic [31:0] w1);
        vin   = v;
        lv_in = lv;
        insn  = {w1, w0};
    endtask

    function automatic logic [31:0] rword();
        logic [31:0] w;
        int r;
        w = $urandom;
        r = $urandom_range(0, 9);
        if (r < 2) return w;
        w[31:26] = 6'd31;
        if (r < 8) w[9:1] = 9'(tbl_xop[$urandom_range(0, 24)]);
        return w;
    endfunction

    task automatic push_rand();
        drive(1'b1, 2'($urandom_range(0, 3)), rword(), rword());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; rdy_in = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        step(); step();
        rst = 1'b0;
        step();
        chk("reset_valid", 64'(valid_o), 64'd0);
        chk("reset_ready", 64'(ready_o), 64'd1);
        chk("reset_illcnt", 64'(illcnt_o), 64'd0);

        // add r3,r4,r5 in lane0 and addi in lane1
        rdy_in = 1'b1;
        drive(1'b1, 2'b11, 32'h7C642A14, 32'h38600001);
        step();
        vin = 1'b0;
        chk("t1_valid", 64'(valid_o), 64'd1);
        chk("t1_lv0", 64'(laneValid_o[0]), 64'd1);
        chk("t1_regs", 64'({reg1_o[4:0], reg2_o[4:0], reg3_o[4:0]}), 64'({5'd3, 5'd4, 5'd5}));
        chk("t1_xop", 64'(xop_o[8:0]), 64'd266);
        chk("t1_unit_idx", 64'({unit_o[1:0], opIdx_o[4:0]}), 64'd0);
        chk("t1_lane1", 64'({laneValid_o[1], illegal_o[1]}), 64'd0);
        step();

        // mulhd, then mulhd with OE (no OE form -> illegal)
        drive(1'b1, 2'b01, 32'h7C221892, 32'h0);
        step();
        chk("t2_unit", 64'(unit_o[1:0]), 64'd1);
        chk("t2_idx", 64'(opIdx_o[4:0]), 64'd18);
        chk("t2_oe", 64'(oe_o[0]), 64'd0);
        drive(1'b1, 2'b01, 32'h7C221C92, 32'h0);
        step();
        vin = 1'b0;
        chk("t2_ill", 64'({illegal_o[0], laneValid_o[0]}), 64'b10);
        chk("t2_illcnt", 64'(illcnt_o), 64'd1);
        step(); step();

        // fill with consumer stalled; fifth bundle held off
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) begin push_rand(); step(); end
        chk("t3_full_ready", 64'(ready_o), 64'd0);
        push_rand();
        step(); step();
        chk("t3_held_ready", 64'(ready_o), 64'd0);
        rdy_in = 1'b1;
        begin
            bit got;
            got = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                got = ready_o;
                step();
            end
            chk("t3_fifth_accepted", 64'(got), 64'd1);
        end
        vin = 1'b0;
        repeat (6) step();

        // steady state at occupancy 2 with simultaneous push/pop
        rdy_in = 1'b0;
        for (int i = 0; i < 2; i++) begin push_rand(); step(); end
        rdy_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_rand();
            step();
            chk("t4_ready", 64'({ready_o, valid_o}), 64'b11);
        end
        vin = 1'b0;
        repeat (4) step();

        // flush with 3 queued and a bundle offered in the same cycle
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin push_rand(); step(); end
        push_rand();
        flush = 1'b1;
        step();
        flush = 1'b0;
        vin   = 1'b0;
        chk("t5_valid", 64'(valid_o), 64'd0);
        chk("t5_ready", 64'(ready_o), 64'd1);
        rdy_in = 1'b1;
        repeat (3) step();

        // async reset in the middle of a burst
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin push_rand(); step(); end
        #1 rst = 1'b1;
        #1;
        chk("t6_valid", 64'(valid_o), 64'd0);
        chk("t6_illcnt", 64'(illcnt_o), 64'd0);
        @(negedge clk);
        step();
        rst = 1'b0;
        drive(1'b1, 2'b11, 32'h7C642A14, 32'h7C221892);
        step();
        vin = 1'b0;
        chk("t6_after_reset", 64'(valid_o), 64'd1);
        rdy_in = 1'b1;
        step();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) != 0) push_rand();
            else vin = 1'b0;
            rdy_in = ($urandom_range(0, 9) < 7);
            flush  = ($urandom_range(0, 49) == 0);
            step();
        end
        vin = 1'b0; flush = 1'b0; rdy_in = 1'b1;
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
